// File: rtl/control_filtro_if.sv
// Bus bundle between the filter sequencer and its environment.
//   slave  : seen by control_filtro (sample/coef inputs, datapath operands, results)
//   master : seen by the source/datapath/sink side (drives sample, coef and mac_result)
// Signals:
//   sample_tick, x_in              new-sample strobe and signed sample word
//   coef_we, coef_addr, coef_data  coefficient bank write port
//   op_const, op_mult, op_acc      operands to the shared MAC datapath
//   mac_result                     MAC result, Q(2*FRAC), 2N bits
//   y_out, y_valid                 filtered output and its one-cycle strobe
//   busy, overrun                  sequencer status
interface control_filtro_if #(
    parameter int unsigned N      = 25,
    parameter int unsigned ADDR_W = 2
);
    logic              sample_tick;
    logic [N-1:0]      x_in;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [N-1:0]      coef_data;
    logic [N-1:0]      op_const;
    logic [N-1:0]      op_mult;
    logic [N-1:0]      op_acc;
    logic [2*N-1:0]    mac_result;
    logic [N-1:0]      y_out;
    logic              y_valid;
    logic              busy;
    logic              overrun;

    modport master (
        output sample_tick, x_in, coef_we, coef_addr, coef_data, mac_result,
        input  op_const, op_mult, op_acc, y_out, y_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, x_in, coef_we, coef_addr, coef_data, mac_result,
        output op_const, op_mult, op_acc, y_out, y_valid, busy, overrun
    );
endinterface

// File: rtl/control_filtro.sv
// Sequencer for the shared multiply-accumulate datapath of an FIR filter.
// Per accepted sample it walks TAPS coefficient/sample pairs through the external
// combinational MAC, one per clock, feeding each truncated result back as the next
// accumulator operand, and emits one filtered word per sample.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : control_filtro_if.slave (sample in, coef writes, MAC operands/result,
//                y_out/y_valid, busy, overrun)
// Build option: define CONTROL_FILTRO_SAT_EN to saturate the Q-format truncation
// instead of letting it wrap.
module control_filtro #(
    parameter int unsigned N      = 25,
    parameter int unsigned TAPS   = 4,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned FRAC   = 12
) (
    input logic             clk,
    input logic             reset,
    control_filtro_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [N-1:0]      acc_q;
    logic [N-1:0]      y_out_q;
    logic              y_valid_q;
    logic              busy_q;
    logic              overrun_q;
    logic [N-1:0]      x_q    [TAPS];
    logic [N-1:0]      coef_q [TAPS];

    // Truncate the Q(2*FRAC) MAC result back to an N-bit Q(FRAC) word.
    logic [N-1:0]    mac_trunc;
    logic [N-FRAC:0] mac_top;
    assign mac_top = bus.mac_result[2*N-1:N+FRAC-1];

    always_comb begin
        mac_trunc = bus.mac_result[N+FRAC-1:FRAC];
`ifdef CONTROL_FILTRO_SAT_EN
        // Discarded high bits disagree with the kept sign bit: clamp by true sign.
        if (mac_top != '0 && mac_top != '1) begin
            mac_trunc = mac_top[N-FRAC] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    logic unused_mac;
    assign unused_mac = ^{mac_top, bus.mac_result[FRAC-1:0]};

    logic coef_addr_ok;
    assign coef_addr_ok = {1'b0, bus.coef_addr} < (ADDR_W + 1)'(TAPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            y_valid_q <= 1'b0;

            if (bus.sample_tick && busy_q) begin
                overrun_q <= 1'b1;
            end

            // Bank is frozen while a computation runs; a write alongside an accepted
            // tick lands before MAC starts, so that sample sees the new value.
            if (bus.coef_we && !busy_q && coef_addr_ok) begin
                coef_q[bus.coef_addr] <= bus.coef_data;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.sample_tick) begin
                        for (int unsigned i = TAPS - 1; i > 0; i--) begin
                            x_q[i] <= x_q[i-1];
                        end
                        x_q[0]  <= bus.x_in;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= mac_trunc;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == ADDR_W'(TAPS - 1)) begin
                        y_out_q   <= mac_trunc;
                        y_valid_q <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Operands are only meaningful during MAC; hold them at zero otherwise.
    always_comb begin
        bus.op_acc   = '0;
        bus.op_mult  = '0;
        bus.op_const = '0;
        if (state_q == StMac) begin
            bus.op_acc   = acc_q;
            bus.op_mult  = x_q[idx_q];
            bus.op_const = coef_q[idx_q];
        end
    end

    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_control_filtro.sv
module tb_control_filtro;

    localparam int unsigned N      = 25;
    localparam int unsigned TAPS   = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned FRAC   = 12;

    logic clk;
    logic reset;

    control_filtro_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    control_filtro #(.N(N), .TAPS(TAPS), .ADDR_W(ADDR_W), .FRAC(FRAC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural MAC datapath: sign-extended, FRAC-aligned acc plus the full product.
    logic [2*N-1:0] prod;
    assign prod = $signed({{N{bus.op_mult[N-1]}}, bus.op_mult})
                * $signed({{N{bus.op_const[N-1]}}, bus.op_const});
    assign bus.mac_result = {{(N-FRAC){bus.op_acc[N-1]}}, bus.op_acc, {FRAC{1'b0}}} + prod;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint y;
        int     cyc;
    } exp_t;

    exp_t   sb_q[$];
    longint x_m    [TAPS];
    longint coef_m [TAPS];
    bit     have_acc;
    int     last_acc;
    int     ovr_from;

    function automatic longint sx(input logic [N-1:0] v);
        return longint'($signed(v));
    endfunction

    // Q(2*FRAC) -> Q(FRAC) word, N bits signed.
    function automatic longint trunc_m(input longint full);
        longint q;
        longint half;
        half = longint'(1) << (N - 1);
        q = full >>> FRAC;
`ifdef CONTROL_FILTRO_SAT_EN
        if (q > half - 1) return half - 1;
        if (q < -half) return -half;
        return q;
`else
        q = q & ((longint'(1) << N) - 1);
        if (q >= half) q = q - (longint'(1) << N);
        return q;
`endif
    endfunction

    function automatic bit busy_m(input int c);
        return have_acc && c > last_acc && c <= last_acc + int'(TAPS) + 1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) begin
            x_m[i]    = 0;
            coef_m[i] = 0;
        end
        have_acc = 0;
        last_acc = 0;
        ovr_from = -1;
        sb_q.delete();
    endfunction

    function automatic void model_cycle(input bit tick, input logic [N-1:0] x, input bit we,
                                        input logic [ADDR_W-1:0] a, input logic [N-1:0] d);
        longint acc;
        exp_t   e;
        bit     b;
        b = busy_m(cyc);
        if (we && !b && int'(a) < int'(TAPS)) coef_m[a] = sx(d);
        if (tick) begin
            if (b) begin
                if (ovr_from < 0) ovr_from = cyc + 1;
            end else begin
                for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
                x_m[0] = sx(x);
                acc = 0;
                for (int t = 0; t < TAPS; t++) begin
                    acc = trunc_m(acc * (longint'(1) << FRAC) + x_m[t] * coef_m[t]);
                end
                e.y   = acc;
                e.cyc = cyc + int'(TAPS) + 1;
                sb_q.push_back(e);
                have_acc = 1;
                last_acc = cyc;
            end
        end
    endfunction

    // ---------------- monitor ----------------
    exp_t e_mon;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", longint'(bus.busy), longint'(busy_m(cyc)));
            chk("overrun", longint'(bus.overrun), longint'(ovr_from >= 0 && cyc >= ovr_from));
            if (bus.y_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_y_valid", 1, 0);
                end else begin
                    e_mon = sb_q.pop_front();
                    chk("y_out", sx(bus.y_out), e_mon.y);
                    chk("y_valid_cycle", longint'(cyc), longint'(e_mon.cyc));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit tick, input logic [N-1:0] x, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [N-1:0] d);
        bus.sample_tick = tick;
        bus.x_in        = x;
        bus.coef_we     = we;
        bus.coef_addr   = a;
        bus.coef_data   = d;
        model_cycle(tick, x, we, a, d);
        @(posedge clk);
        #1;
        cyc++;
        bus.sample_tick = 1'b0;
        bus.coef_we     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic tick(input logic [N-1:0] x);
        drive(1'b1, x, 1'b0, '0, '0);
    endtask

    task automatic wcoef(input logic [ADDR_W-1:0] a, input logic [N-1:0] d);
        drive(1'b0, '0, 1'b1, a, d);
    endtask

    task automatic do_reset(input int n, input bit tick_hi);
        reset           = 1'b1;
        bus.sample_tick = tick_hi;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            model_clear();
        end
        reset           = 1'b0;
        bus.sample_tick = 1'b0;
    endtask

    function automatic logic [N-1:0] rand_word(input int small_bits);
        logic [31:0] r;
        logic [N-1:0] v;
        r = $urandom;
        v = r[N-1:0];
        if ($urandom_range(0, 3) != 0) begin
            v = r[N-1:0] & ((N'(1) << small_bits) - 1'b1);
            if (r[31]) v = -v;
        end
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.sample_tick = 1'b0;
        bus.x_in        = '0;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_data   = '0;
        model_clear();

        // Reset with sample_tick held high.
        do_reset(2, 1'b1);
        chk("rst_y_out", longint'(bus.y_out), 0);
        chk("rst_y_valid", longint'(bus.y_valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_overrun", longint'(bus.overrun), 0);
        chk("rst_op_acc", longint'(bus.op_acc), 0);
        chk("rst_op_mult", longint'(bus.op_mult), 0);
        chk("rst_op_const", longint'(bus.op_const), 0);
        mon_en = 1;
        idle(2);

        // Impulse response: 4096, 2048, 1024, 512, 0.
        wcoef(0, 25'd4096);
        wcoef(1, 25'd2048);
        wcoef(2, 25'd1024);
        wcoef(3, 25'd512);
        tick(25'd4096);
        idle(5);
        for (int i = 0; i < 4; i++) begin
            tick('0);
            idle(5);
        end
        idle(3);

        // Overrun: second tick three cycles after the first is dropped.
        tick(25'd4096);
        idle(2);
        tick(25'd1000);
        idle(8);
        tick(25'd12);   // accepted; overrun remains sticky
        idle(8);
        do_reset(1, 1'b0);
        idle(1);

        // Coefficient lock: write coef[2] while busy, then read it back by impulse.
        wcoef(0, 25'd4096);
        wcoef(1, 25'd2048);
        wcoef(2, 25'd1024);
        wcoef(3, 25'd512);
        tick(25'd4096);
        idle(1);
        wcoef(2, 25'd8192);
        idle(3);
        tick('0);
        idle(5);
        tick('0);
        idle(8);

        // Saturation / wrap: 4.0 * 2048.0 overflows the output word.
        wcoef(0, 25'd16384);
        wcoef(1, '0);
        wcoef(2, '0);
        wcoef(3, '0);
        tick(25'd8388608);
        idle(8);

        // Reset during MAC: aborted sample produces nothing, delay line cleared.
        tick(25'd4096);
        idle(2);
        do_reset(1, 1'b0);
        wcoef(0, 25'd4096);
        wcoef(1, '0);
        wcoef(2, '0);
        wcoef(3, '0);
        tick(25'd4096);
        idle(8);

        // Same-cycle coefficient write and tick: the new value is used.
        drive(1'b1, 25'd8192, 1'b1, 2'd0, 25'd2048);
        idle(8);

        // Randomised traffic.
        for (int it = 0; it < 600; it++) begin
            bit do_tick;
            bit do_we;
            do_tick = ($urandom_range(0, 3) == 0);
            do_we   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 150) == 0) begin
                do_reset(1, 1'(($urandom & 1) != 0));
            end else begin
                drive(do_tick, rand_word(16), do_we, ADDR_W'($urandom_range(0, TAPS - 1)),
                      rand_word(14));
            end
        end

        // Drain pending outputs within a bounded number of cycles.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) idle(1);
        chk("drain_empty", longint'(sb_q.size()), 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
